// File: rtl/time_set_pkg.sv
// rtl/time_set_pkg.sv - shared types, ASCII codes and digit limits for time entry
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_S_UP  = 8'h53;
  localparam logic [7:0] ASCII_S_LO  = 8'h73;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BLANK = 8'h5F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [31:0] ENTRY_BLANK = {4{ASCII_BLANK}};

  localparam logic [3:0] LIM_POS0      = 4'd2;
  localparam logic [3:0] LIM_POS1      = 4'd9;
  localparam logic [3:0] LIM_POS1_HR20 = 4'd3;
  localparam logic [3:0] LIM_POS2      = 4'd5;
  localparam logic [3:0] LIM_POS3      = 4'd9;

  // Largest digit accepted at a position; hour units are capped once hour tens is 2.
  function automatic logic [3:0] digit_limit(input logic [1:0] pos, input logic [3:0] first);
    logic [3:0] lim;
    case (pos)
      2'd0:    lim = LIM_POS0;
      2'd1:    lim = (first == 4'd2) ? LIM_POS1_HR20 : LIM_POS1;
      2'd2:    lim = LIM_POS2;
      default: lim = LIM_POS3;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/ascii2num.sv
// rtl/ascii2num.sv - combinational ASCII digit decoder
module ascii2num
  import time_set_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic       is_digit_o,
  output logic [3:0] value_o
);

  logic [7:0] offset;

  // Codes below '0' wrap to large offsets, so a single upper compare suffices.
  always_comb begin
    offset     = ascii_i - ASCII_ZERO;
    is_digit_o = (offset <= 8'd9);
    value_o    = is_digit_o ? offset[3:0] : 4'd0;
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - keyboard-driven HH:MM entry that loads a clock block field by field
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TICKS_PER_FIELD = 1
)
(
  input  logic        CLOCK_50,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  input  logic        tick,
  output logic        pause,
  output logic [1:0]  sel,
  output logic [3:0]  load,
  output logic        busy,
  output logic        err,
  output logic [31:0] entry_ascii
);

  localparam int TW = (TICKS_PER_FIELD > 1) ? $clog2(TICKS_PER_FIELD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FIELD - 1);

  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [1:0]    field_q, field_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [31:0]   entry_q, entry_d;
  logic          err_q, err_d;

  logic          key_is_digit;
  logic [3:0]    key_value;
  logic          key_is_start;
  logic [1:0]    bs_pos;

  ascii2num u_ascii2num (
    .ascii_i    (key_ascii),
    .is_digit_o (key_is_digit),
    .value_o    (key_value)
  );

  assign key_is_start = (key_ascii == ASCII_S_UP) || (key_ascii == ASCII_S_LO);
  assign bs_pos       = count_q[1:0] - 2'd1;

  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      count_q    <= 3'd0;
      field_q    <= 2'd0;
      tick_cnt_q <= '0;
      entry_q    <= ENTRY_BLANK;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      field_q    <= field_d;
      tick_cnt_q <= tick_cnt_d;
      entry_q    <= entry_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    field_d    = field_q;
    tick_cnt_d = tick_cnt_q;
    entry_d    = entry_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_is_start) begin
          state_d = ST_ENTRY;
          count_d = 3'd0;
          entry_d = ENTRY_BLANK;
        end
      end

      ST_ENTRY: begin
        if (key_valid) begin
          if (key_is_start) begin
            count_d = 3'd0;
            entry_d = ENTRY_BLANK;
          end else if (key_ascii == ASCII_ESC) begin
            state_d = ST_IDLE;
          end else if (key_ascii == ASCII_BS) begin
            if (count_q != 3'd0) begin
              count_d = count_q - 3'd1;
              entry_d[8*(3-int'(bs_pos)) +: 8] = ASCII_BLANK;
            end
          end else if (key_ascii == ASCII_CR) begin
            if (count_q == 3'd4) begin
              state_d    = ST_APPLY;
              field_d    = 2'd0;
              tick_cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_is_digit && (count_q != 3'd4) &&
                       (key_value <= digit_limit(count_q[1:0], entry_q[27:24]))) begin
            // The echo byte's low nibble doubles as the stored BCD digit.
            entry_d[8*(3-int'(count_q[1:0])) +: 8] = {4'h3, key_value};
            count_d = count_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_APPLY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (field_q == 2'd3) begin
              state_d = ST_IDLE;
            end else begin
              field_d = field_q + 2'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Fields go out hour tens first, so sel counts down while field_q counts up.
  assign pause       = (state_q == ST_APPLY);
  assign sel         = pause ? (2'd3 - field_q) : 2'd0;
  assign load        = pause ? entry_q[8*(3-int'(field_q)) +: 4] : 4'd0;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign entry_ascii = entry_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl with a queue-based reference model
module tb_time_set_ctrl;

  localparam int TPF = 2;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = 8'h00;
  logic        tick = 1'b0;
  logic        pause;
  logic [1:0]  sel;
  logic [3:0]  load;
  logic        busy;
  logic        err;
  logic [31:0] entry_ascii;

  time_set_ctrl #(.TICKS_PER_FIELD(TPF)) dut (
    .CLOCK_50    (clk),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_ascii   (key_ascii),
    .tick        (tick),
    .pause       (pause),
    .sel         (sel),
    .load        (load),
    .busy        (busy),
    .err         (err),
    .entry_ascii (entry_ascii)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        k_err;
    logic [31:0] k_entry;
    logic        k_busy;
  } key_rec_t;

  typedef struct {
    logic [1:0] f_sel;
    logic [3:0] f_load;
  } fld_rec_t;

  key_rec_t exp_key[$];
  fld_rec_t exp_fld[$];
  fld_rec_t pending[$];
  int       digits[$];
  int       mode = 0;
  int       n_cmp = 0;
  int       n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_echo();
    logic [31:0] e;
    for (int p = 0; p < 4; p++)
      e[8*(3-p) +: 8] = (p < digits.size()) ? 8'(8'h30 + digits[p]) : 8'h5F;
    return e;
  endfunction

  function automatic void model_reset();
    mode = 0;
    digits.delete();
    pending.delete();
  endfunction

  // Mode 0 idle, 1 entering digits, 2 applying; pending holds every capture still owed.
  function automatic void model_step(input logic kv, input logic [7:0] key, input logic tk);
    logic e;
    int   d, n, lim;
    e = 1'b0;
    case (mode)
      0: if (kv && (key == 8'h53 || key == 8'h73)) begin
        mode = 1;
        digits.delete();
      end
      1: if (kv) begin
        if (key == 8'h53 || key == 8'h73) digits.delete();
        else if (key == 8'h1B) mode = 0;
        else if (key == 8'h08) begin
          if (digits.size() > 0) void'(digits.pop_back());
        end else if (key == 8'h0D) begin
          if (digits.size() == 4) begin
            mode = 2;
            for (int f = 0; f < 4; f++)
              for (int t = 0; t < TPF; t++)
                pending.push_back('{f_sel: 2'(3 - f), f_load: 4'(digits[f])});
          end else e = 1'b1;
        end else if (key >= 8'h30 && key <= 8'h39) begin
          d = int'(key) - 48;
          n = digits.size();
          if (n == 0) lim = 2;
          else if (n == 1) lim = (digits[0] == 2) ? 3 : 9;
          else if (n == 2) lim = 5;
          else lim = 9;
          if (n < 4 && d <= lim) digits.push_back(d);
          else e = 1'b1;
        end else e = 1'b1;
      end
      default: if (tk) begin
        exp_fld.push_back(pending.pop_front());
        if (pending.size() == 0) mode = 0;
      end
    endcase
    if (kv) exp_key.push_back('{k_err: e, k_entry: model_echo(), k_busy: (mode != 0)});
  endfunction

  task automatic step(input logic kv, input logic [7:0] key, input logic tk);
    @(posedge clk);
    #1;
    key_valid = kv;
    key_ascii = key;
    tick      = tk;
    model_step(kv, key, tk);
  endtask

  task automatic press(input logic [7:0] key);
    step(1'b1, key, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input int gap, input logic with_keys);
    int guard;
    guard = 0;
    while (mode == 2 && guard < 100) begin
      repeat (gap - 1) step(1'b0, 8'h00, 1'b0);
      step(with_keys, with_keys ? 8'($urandom) : 8'h00, 1'b1);
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_bad++;
      $display("FAIL apply_timeout: got %0d ticks expected completion", guard);
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin : monitor
    logic     key_due;
    key_rec_t kr;
    fld_rec_t fr;
    key_due = 1'b0;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        key_due = 1'b0;
        continue;
      end
      if (key_due) begin
        if (exp_key.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL key_result: got response expected none queued");
        end else begin
          kr = exp_key.pop_front();
          chk("err", 32'(err), 32'(kr.k_err));
          chk("entry_ascii", entry_ascii, kr.k_entry);
          chk("busy", 32'(busy), 32'(kr.k_busy));
        end
      end else begin
        chk("err_quiet", 32'(err), 32'd0);
      end
      if (tick && pause) begin
        if (exp_fld.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL field_capture: got sel=%0d load=%0d expected no capture", sel, load);
        end else begin
          fr = exp_fld.pop_front();
          chk("sel", 32'(sel), 32'(fr.f_sel));
          chk("load", 32'(load), 32'(fr.f_load));
        end
      end
      if (!pause) chk("sel_load_idle", {26'd0, sel, load}, 32'd0);
      key_due = key_valid;
    end
  end

  initial begin : stim
    logic [7:0] k;
    int         r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_entry", entry_ascii, 32'h5F5F5F5F);
    chk("rst_sel_load", {26'd0, sel, load}, 32'd0);
    clrn = 1'b1;

    press(8'h53); press(8'h31); press(8'h32); press(8'h33); press(8'h34); press(8'h0D);
    drain(10, 1'b0);
    chk("apply_done_busy", 32'(busy), 32'd0);
    chk("apply_done_pause", 32'(pause), 32'd0);
    chk("apply_done_entry", entry_ascii, 32'h31323334);

    press(8'h53); press(8'h32); press(8'h34); press(8'h33); press(8'h35); press(8'h39);
    step(1'b1, 8'h0D, 1'b1);
    drain(3, 1'b1);

    press(8'h73); press(8'h30); press(8'h36); press(8'h37); press(8'h08); press(8'h08);
    press(8'h08); press(8'h08);
    press(8'h53); press(8'h31); press(8'h32); press(8'h0D); press(8'h1B);
    press(8'h41);

    press(8'h53); press(8'h32); press(8'h33); press(8'h35); press(8'h39); press(8'h0D);
    for (int i = 0; i < 2 * TPF; i++) begin
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    tick      = 1'b0;
    clrn      = 1'b0;
    model_reset();
    #1;
    chk("rst_apply_pause", 32'(pause), 32'd0);
    chk("rst_apply_entry", entry_ascii, 32'h5F5F5F5F);
    chk("rst_apply_busy", 32'(busy), 32'd0);
    chk("rst_apply_sel_load", {26'd0, sel, load}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 19));
      if (r <= 9) k = 8'(8'h30 + r);
      else if (r == 10 || r >= 18) k = 8'(8'h30 + $urandom_range(0, 2));
      else if (r == 11) k = 8'h53;
      else if (r == 12) k = 8'h73;
      else if (r == 13) k = 8'h08;
      else if (r == 14) k = 8'h1B;
      else if (r <= 16) k = 8'h0D;
      else k = 8'($urandom);
      step(($urandom_range(0, 2) == 0), k, ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 8'h00, 1'b0);
    drain(2, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    chk("key_queue_empty", 32'(exp_key.size()), 32'd0);
    chk("field_queue_empty", 32'(exp_fld.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
